// File: rtl/a2d_sched_pkg.sv
// ============================================================================
// a2d_sched_pkg : shared widths and FSM state type for the A2D scan scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package a2d_sched_pkg;

  localparam int CH_W   = 3;
  localparam int RES_W  = 12;
  localparam int NUM_CH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BLANK = 3'd2,
    WAIT  = 3'd3,
    STORE = 3'd4,
    GAP   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/a2d_scan_sched_if.sv
// ============================================================================
// a2d_scan_sched_if : converter link between the scheduler and A2D_intf
// Rev 1.0
// ============================================================================
`default_nettype none

interface a2d_scan_sched_if;
  import a2d_sched_pkg::*;

  logic             strt_cnv;
  logic [CH_W-1:0]  chnnl;
  logic             cnv_cmplt;
  logic [RES_W-1:0] res;

  modport master (output strt_cnv, chnnl, input cnv_cmplt, res);
  modport slave  (input strt_cnv, chnnl, output cnv_cmplt, res);

endinterface

`default_nettype wire

// File: rtl/a2d_next_ch.sv
// ============================================================================
// a2d_next_ch : next set bit above cur_ch in mask; wraps to the lowest set bit
// Rev 1.0
// ============================================================================
`default_nettype none

module a2d_next_ch
  import a2d_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur_ch,
  output logic [CH_W-1:0]   nxt_ch,
  output logic              wrap
);

  logic [CH_W-1:0] lo_ch;
  logic [CH_W-1:0] hi_ch;
  logic            hi_found;

  // Descending scan: the last hit is the lowest qualifying bit.
  always_comb begin
    lo_ch    = '0;
    hi_ch    = '0;
    hi_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lo_ch = CH_W'(i);
        if (CH_W'(i) > cur_ch) begin
          hi_ch    = CH_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    nxt_ch = hi_found ? hi_ch : lo_ch;
    wrap   = !hi_found;
  end

endmodule

`default_nettype wire

// File: rtl/a2d_scan_sched.sv
// ============================================================================
// a2d_scan_sched : round-robin IR channel scanner sharing A2D_intf with one
//                  on-demand requester. Optional macro A2D_AVG2_EN averages two
//                  back-to-back conversions per scan channel.
// Rev 1.0
// ============================================================================
`default_nettype none

module a2d_scan_sched
  import a2d_sched_pkg::*;
#(
  parameter int SCAN_GAP    = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scan_en,
  input  logic [NUM_CH-1:0]  ch_mask,
  a2d_scan_sched_if.master   a2d,
  input  logic [CH_W-1:0]    rd_ch,
  output logic [RES_W-1:0]   rd_data,
  output logic [NUM_CH-1:0]  res_vld,
  output logic               scan_done,
  input  logic               ond_req,
  input  logic [CH_W-1:0]    ond_ch,
  output logic               ond_gnt,
  output logic [RES_W-1:0]   ond_res,
  output logic               err
);

  localparam int CNT_MAX = (TIMEOUT_CYC > SCAN_GAP) ? TIMEOUT_CYC : SCAN_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TMO_LD = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(SCAN_GAP - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   scan_ch;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] vld_q;
  logic              scan_act;
  logic              fair;
  logic              is_ond;
  logic              done_q;
  logic              err_q;
  logic [RES_W-1:0]  ond_res_q;
  logic [RES_W-1:0]  file_q [NUM_CH];

  logic [NUM_CH-1:0] fnd_mask;
  logic [CH_W-1:0]   fnd_cur;
  logic [CH_W-1:0]   nxt_ch;
  logic              wrap;
  logic              again;
  logic              last_pass;
  logic [RES_W-1:0]  store_val;

  // Idle scanner: first channel of a fresh scan; active: successor of scan_ch.
  assign fnd_mask = scan_act ? mask_q  : ch_mask;
  assign fnd_cur  = scan_act ? scan_ch : CH_W'(NUM_CH - 1);

  a2d_next_ch u_next_ch (
    .mask   (fnd_mask),
    .cur_ch (fnd_cur),
    .nxt_ch (nxt_ch),
    .wrap   (wrap)
  );

  logic wcmp, wtmo, arb_pt, scan_go_start, scan_go_next, scan_avail, pick_ond, pick_scan;

  assign wcmp          = (state == WAIT) && a2d.cnv_cmplt;
  assign wtmo          = (state == WAIT) && !a2d.cnv_cmplt && (cnt == '0);
  assign arb_pt        = (state == IDLE) || ((state == GAP) && (cnt == '0) && !again);
  assign scan_go_start = !scan_act && scan_en && (ch_mask != '0);
  assign scan_go_next  = scan_act && scan_en;
  assign scan_avail    = scan_go_start || scan_go_next;
  // Fairness only matters while a scan channel is waiting; otherwise serve at once.
  assign pick_ond      = ond_req && (!fair || !scan_avail);
  assign pick_scan     = scan_avail && !pick_ond;

`ifdef A2D_AVG2_EN
  logic             pass;
  logic [RES_W-1:0] first_q;
  logic [RES_W:0]   sum;

  assign sum       = {1'b0, first_q} + {1'b0, a2d.res} + {{RES_W{1'b0}}, 1'b1};
  assign store_val = RES_W'(sum >> 1);
  assign again     = pass;
  assign last_pass = pass;

  always_ff @(posedge clk) begin
    if (rst) begin
      pass    <= 1'b0;
      first_q <= '0;
    end else if (wcmp && !is_ond) begin
      if (!pass) begin
        first_q <= a2d.res;
        pass    <= 1'b1;
      end else begin
        pass <= 1'b0;
      end
    end else if (wtmo) begin
      pass <= 1'b0;
    end
  end
`else
  assign store_val = a2d.res;
  assign again     = 1'b0;
  assign last_pass = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (pick_ond || pick_scan) state_nxt = START;
      START: state_nxt = BLANK;
      BLANK: state_nxt = WAIT;
      WAIT: begin
        if (a2d.cnv_cmplt)  state_nxt = STORE;
        else if (cnt == '0) state_nxt = GAP;
      end
      STORE: state_nxt = GAP;
      GAP: begin
        if (cnt == '0) begin
          if (again || pick_ond || pick_scan) state_nxt = START;
          else                                state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a2d.strt_cnv = (state == START);
    a2d.chnnl    = cur_ch;
    ond_gnt      = (state == STORE) && is_ond;
    scan_done    = (state == STORE) && done_q;
    err          = err_q;
    rd_data      = file_q[rd_ch];
    res_vld      = vld_q;
    ond_res      = ond_res_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      cur_ch    <= '0;
      scan_ch   <= '0;
      mask_q    <= '0;
      vld_q     <= '0;
      scan_act  <= 1'b0;
      fair      <= 1'b0;
      is_ond    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ond_res_q <= '0;
      for (int i = 0; i < NUM_CH; i++) file_q[i] <= '0;
    end else begin
      err_q <= wtmo;

      if (state == BLANK)
        cnt <= TMO_LD;
      else if ((state == STORE) || wtmo)
        cnt <= GAP_LD;
      else if (((state == WAIT) || (state == GAP)) && (cnt != '0))
        cnt <= cnt - 1'b1;

      if (arb_pt && scan_act && !scan_en) scan_act <= 1'b0;

      if (arb_pt && pick_ond) begin
        is_ond <= 1'b1;
        cur_ch <= ond_ch;
        fair   <= 1'b1;
      end else if (arb_pt && pick_scan) begin
        is_ond  <= 1'b0;
        fair    <= 1'b0;
        cur_ch  <= nxt_ch;
        scan_ch <= nxt_ch;
        if (!scan_act) begin
          mask_q   <= ch_mask;
          scan_act <= 1'b1;
        end
      end

      // Results land at the completing edge so they are readable during STORE.
      if (wcmp) begin
        done_q <= !is_ond && last_pass && wrap && scan_en;
        if (is_ond) begin
          ond_res_q <= a2d.res;
        end else if (last_pass) begin
          file_q[scan_ch] <= store_val;
          vld_q[scan_ch]  <= 1'b1;
          if (wrap) scan_act <= 1'b0;
        end
      end

      if (wtmo && !is_ond) begin
        vld_q[scan_ch] <= 1'b0;
        if (wrap) scan_act <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_a2d_scan_sched.sv
// ============================================================================
// tb_a2d_scan_sched : directed bench with a 40-cycle stub converter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_a2d_scan_sched;
  import a2d_sched_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              scan_en;
  logic [NUM_CH-1:0] ch_mask;
  logic [CH_W-1:0]   rd_ch;
  logic [RES_W-1:0]  rd_data;
  logic [NUM_CH-1:0] res_vld;
  logic              scan_done;
  logic              ond_req;
  logic [CH_W-1:0]   ond_ch;
  logic              ond_gnt;
  logic [RES_W-1:0]  ond_res;
  logic              err;

  a2d_scan_sched_if a2d_bus ();

  a2d_scan_sched #(.SCAN_GAP(16), .TIMEOUT_CYC(4096)) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_en   (scan_en),
    .ch_mask   (ch_mask),
    .a2d       (a2d_bus.master),
    .rd_ch     (rd_ch),
    .rd_data   (rd_data),
    .res_vld   (res_vld),
    .scan_done (scan_done),
    .ond_req   (ond_req),
    .ond_ch    (ond_ch),
    .ond_gnt   (ond_gnt),
    .ond_res   (ond_res),
    .err       (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int q[$];
  int done_cnt = 0;
  int gnt_cnt  = 0;
  int err_cnt  = 0;
  int stub_cnt = 0;
  logic [CH_W-1:0] stub_ch = '0;
  logic silent2 = 1'b0;

  // Stub converter: completes 40 cycles after strt_cnv, optionally mute on ch2.
  always @(negedge clk) begin
    if (rst) begin
      stub_cnt = 0;
      a2d_bus.cnv_cmplt = 1'b0;
      a2d_bus.res = '0;
    end else begin
      a2d_bus.cnv_cmplt = 1'b0;
      if (a2d_bus.strt_cnv) begin
        stub_cnt = 40;
        stub_ch  = a2d_bus.chnnl;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0 && !(silent2 && stub_ch == 3'd2)) begin
          a2d_bus.cnv_cmplt = 1'b1;
          a2d_bus.res = {stub_ch, 9'h0A5};
        end
      end
    end
  end

  always @(negedge clk) begin
    if (a2d_bus.strt_cnv) q.push_back(int'(a2d_bus.chnnl));
    if (scan_done) done_cnt++;
    if (ond_gnt)   gnt_cnt++;
    if (err)       err_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  function automatic int get_cnt(input int sel);
    case (sel)
      0:       return q.size();
      1:       return done_cnt;
      2:       return gnt_cnt;
      default: return err_cnt;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int target, input int budget, input string tag);
    int n = 0;
    while (get_cnt(sel) < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(get_cnt(sel) >= target), 32'd1);
  endtask

  int s1, d0, e0, qs, rs;
  int sparse_exp [6] = '{0, 7, 0, 7, 2, 2};

  initial begin
    rst = 1'b1; scan_en = 1'b0; ch_mask = '0; rd_ch = '0; ond_req = 1'b0; ond_ch = '0;
    repeat (3) tick();
    chk("rst_strt", a2d_bus.strt_cnv, 0);
    chk("rst_chnnl", a2d_bus.chnnl, 0);
    chk("rst_vld", res_vld, 0);
    chk("rst_done", scan_done, 0);
    chk("rst_gnt", ond_gnt, 0);
    chk("rst_ondres", ond_res, 0);
    chk("rst_err", err, 0);
    chk("rst_rd", rd_data, 0);
    rst = 1'b0;
    tick();

    // Full scan
    q.delete(); ch_mask = 8'hFF; scan_en = 1'b1;
    wait_for(1, 1, 800, "scan1_done");
    for (int i = 0; i < 8; i++) chk($sformatf("full_seq%0d", i), qat(i), i);
    chk("full_vld", res_vld, 8'hFF);
    rd_ch = 3'd5; #1;
    chk("full_rd5", rd_data, 12'hAA5);
    chk("full_done_cnt", done_cnt, 1);

    // On-demand request held while scanning
    ond_ch = 3'd3; ond_req = 1'b1;
    wait_for(2, 1, 200, "ond1");
    s1 = q.size();
    chk("ond1_qsize", s1, 9);
    chk("ond1_ch", qat(8), 3);
    chk("ond1_res", ond_res, 12'h6A5);
    tick();
    chk("ond1_gnt_width", ond_gnt, 0);
    wait_for(2, 2, 200, "ond2");
    chk("ond2_between", q.size() - s1, 2);
    chk("ond2_scan_ch", qat(9), 0);
    chk("ond2_ch", qat(10), 3);
    ond_req = 1'b0;
    rd_ch = 3'd3; #1;
    chk("ond_file3", rd_data, 12'h6A5);

    // Scanner idle: on-demand served back to back
    scan_en = 1'b0;
    repeat (150) tick();
    chk("idle_no_scan", q.size(), 11);
    ond_ch = 3'd6; ond_req = 1'b1;
    wait_for(2, 3, 100, "ond_idle1");
    chk("ond_idle1_res", ond_res, 12'hCA5);
    ond_req = 1'b0;
    tick();
    ond_ch = 3'd4; ond_req = 1'b1;
    wait_for(2, 4, 100, "ond_idle2");
    chk("ond_idle2_res", ond_res, 12'h8A5);
    ond_req = 1'b0;

    // Reset clears file, then scan_en drops during the first conversion
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_vld", res_vld, 0);
    chk("rst2_ondres", ond_res, 0);
    rd_ch = 3'd5; #1;
    chk("rst2_rd5", rd_data, 0);
    q.delete(); d0 = done_cnt; scan_en = 1'b1;
    wait_for(0, 1, 20, "fall_start");
    scan_en = 1'b0;
    repeat (150) tick();
    chk("fall_qsize", q.size(), 1);
    chk("fall_vld", res_vld, 8'h01);
    chk("fall_no_done", done_cnt - d0, 0);
    rd_ch = 3'd0; #1;
    chk("fall_rd0", rd_data, 12'h0A5);

    // Sparse mask, changed mid-scan
    q.delete(); d0 = done_cnt; ch_mask = 8'h81; scan_en = 1'b1;
    wait_for(0, 3, 400, "sparse3");
    ch_mask = 8'h04;
    wait_for(0, 6, 600, "sparse6");
    for (int i = 0; i < 6; i++) chk($sformatf("sparse_seq%0d", i), qat(i), sparse_exp[i]);
    chk("sparse_done_cnt", done_cnt - d0, 3);

    // Timeout on channel 2
    ch_mask = 8'hFF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete(); d0 = done_cnt; e0 = err_cnt;
    wait_for(1, d0 + 1, 800, "tmo_scan_done");
    silent2 = 1'b1;
    wait_for(3, e0 + 1, 6000, "tmo_err");
    qs = q.size();
    chk("tmo_vld", res_vld, 8'hFB);
    chk("tmo_ch", qat(qs - 1), 2);
    tick();
    chk("tmo_err_width", err, 0);
    wait_for(0, qs + 1, 100, "tmo_next");
    chk("tmo_next_ch", qat(qs), 3);
    silent2 = 1'b0;

    // Reset during WAIT
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("rstw_strt", a2d_bus.strt_cnv, 0);
    chk("rstw_chnnl", a2d_bus.chnnl, 0);
    chk("rstw_vld", res_vld, 0);
    chk("rstw_done", scan_done, 0);
    chk("rstw_err", err, 0);
    chk("rstw_gnt", ond_gnt, 0);
    rs = q.size();
    repeat (5) tick();
    chk("rstw_no_strt", q.size(), rs);
    rst = 1'b0;
    wait_for(0, rs + 1, 10, "rstw_resume");
    chk("rstw_resume_ch", qat(rs), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
